hpdmc_sdrmon: RTL and testbench
===============================

HPDMC_SDRMON -- requirements
Module: hpdmc_sdrmon

Interface
REQ-001 SHALL have parameter sdram_depth, default 25, meaning SDRAM byte-address width.
REQ-002 SHALL have parameter sdram_columndepth, default 10, meaning column address width.
REQ-003 SHALL have port sys_clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports tim_rp, tim_rcd, tim_rfc, tim_refi, inputs, 3/3/4/11 bits, timing values in cycles.
REQ-006 SHALL have ports sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, inputs, 1 each, monitored command bus.
REQ-007 SHALL have ports sdram_adr, input, 13, and sdram_ba, input, 2, monitored address and bank.
REQ-008 SHALL have ports rd_stb and wr_stb, outputs, 1 each, one-cycle pulses for a legal READ or WRITE.
REQ-009 SHALL have port word_adr, output, sdram_depth-1, the reconstructed 32-bit word address, valid with rd_stb/wr_stb.
REQ-010 SHALL have port bank_open, output, 4, per-bank open-row flags.
REQ-011 SHALL have port err_clr, input, 1, clears err_flags.
REQ-012 SHALL have port err_flags, output, 8, sticky violation flags.

Function
REQ-013 SHALL decode {cs_n,ras_n,cas_n,we_n}: 1xxx DESELECT, 0111 NOP, 0011 ACT, 0101 READ, 0100 WRITE, 0010 PRE (adr[10]=1 means all banks), 0001 REF, 0000 LMR.
REQ-014 SHALL keep a per-bank FSM: IDLE -ACT-> ACTIVE; ACTIVE -PRE-> PRECHARGING; PRECHARGING -> IDLE when that bank's rp counter reaches 0.
REQ-015 SHALL store the row (sdram_adr[rowdepth-1:0], rowdepth = sdram_depth-sdram_columndepth-2) per bank on ACT.
REQ-016 SHALL load a bank's rcd counter with tim_rcd on ACT and its rp counter with tim_rp on PRE; counters decrement to 0 and hold.
REQ-017 SHALL load the rfc counter with tim_rfc on REF; while it is nonzero only NOP/DESELECT is legal.
REQ-018 SHALL treat a dependent command as legal only if the governing counter equals 0 in the cycle the command is sampled.
REQ-019 SHALL set err_flags[0] for ACT to a bank not IDLE or with rp counter nonzero.
REQ-020 SHALL set err_flags[1] for READ/WRITE to a bank not ACTIVE, and err_flags[2] for READ/WRITE with rcd counter nonzero.
REQ-021 SHALL set err_flags[3] for REF with any bank not IDLE; err_flags[4] for a non-NOP during tRFC; err_flags[5] for LMR with any bank not IDLE.
REQ-022 SHALL set err_flags[6] when adr[10] is set on a READ/WRITE (auto-precharge unsupported by the controller).
REQ-023 SHALL form word_adr = {row[bank], sdram_ba, sdram_adr[sdram_columndepth-1:1]}, registered, one-cycle latency with the strobes.
REQ-024 SHALL assert rd_stb/wr_stb one cycle after sampling a legal READ/WRITE; an illegal command gives no strobe.
REQ-025 SHALL on PRE-all close every ACTIVE bank and load every rp counter; PRE to an IDLE bank is a legal no-op.
REQ-026 SHALL give err_clr priority lower than a same-cycle new violation: the new bit remains set.
REQ-027 SHALL report several simultaneous violations by setting every applicable bit in one cycle.

Reset
REQ-028 SHALL on sys_rst_n low, asynchronously: all banks IDLE, all counters 0, bank_open 0, err_flags 0, rd_stb/wr_stb 0, word_adr 0.
REQ-029 SHALL treat a reset mid-sequence as returning to the all-IDLE power-up state; no error is raised by the reset itself.

Configuration
REQ-030 SHALL with HPDMC_SDRMON_REFI_CHECK_EN defined include an 11-bit refresh watchdog loaded with tim_refi on REF (and at reset release) and set err_flags[7] when it reaches 0 and a further tim_rfc+4 cycles pass without REF.
REQ-031 SHALL without HPDMC_SDRMON_REFI_CHECK_EN omit the watchdog and tie err_flags[7] to 0.

Structure
REQ-032 SHALL place command encodings, the per-bank state encoding and the err_flags bit indices in a shared package hpdmc_sdrmon_pkg.
REQ-033 SHALL implement the per-bank FSM, row register and rp/rcd counters as sub-module hpdmc_sdrmon_bank, instantiated four times.

Verification
REQ-034 SHALL test: tim_rcd=2; ACT bank1 row 0x123, two NOPs, READ col 0x40 -> rd_stb, word_adr={0x123,2'b01,9'h020}, err_flags=0.
REQ-035 SHALL test: tim_rcd=2; ACT bank0 then WRITE next cycle -> err_flags[2]=1, no wr_stb.
REQ-036 SHALL test: READ to IDLE bank2 -> err_flags[1]=1; err_clr pulse -> err_flags=0.
REQ-037 SHALL test: tim_rp=2, tim_rfc=6; PRE-all, REF after 1 cycle -> err_flags[3]; repeat with correct spacing, then ACT 3 cycles after REF -> err_flags[4].
REQ-038 SHALL test: sys_rst_n asserted while bank3 ACTIVE with rcd counting -> bank_open=0 immediately, subsequent ACT bank3 legal.
REQ-039 SHALL test with HPDMC_SDRMON_REFI_CHECK_EN: tim_refi=20, tim_rfc=6, no REF for 31 cycles -> err_flags[7]=1; without the macro -> err_flags[7]=0.

Source files
------------

// File: rtl/hpdmc_sdrmon_pkg.sv
// Shared SDRAM command-monitor definitions: command encodings, per-bank state
// encoding and err_flags bit positions.
package hpdmc_sdrmon_pkg;

  localparam int NUM_BANKS = 4;

  typedef enum logic [3:0] {
    CMD_LMR   = 4'b0000,
    CMD_REF   = 4'b0001,
    CMD_PRE   = 4'b0010,
    CMD_ACT   = 4'b0011,
    CMD_WRITE = 4'b0100,
    CMD_READ  = 4'b0101,
    CMD_BST   = 4'b0110,
    CMD_NOP   = 4'b0111,
    CMD_DESEL = 4'b1000
  } cmd_t;

  typedef enum logic [1:0] {
    BANK_IDLE        = 2'd0,
    BANK_ACTIVE      = 2'd1,
    BANK_PRECHARGING = 2'd2
  } bank_state_t;

  localparam int ERR_ACT      = 0;
  localparam int ERR_RW_STATE = 1;
  localparam int ERR_RCD      = 2;
  localparam int ERR_REF      = 3;
  localparam int ERR_RFC      = 4;
  localparam int ERR_LMR      = 5;
  localparam int ERR_AUTOPRE  = 6;
  localparam int ERR_REFI     = 7;

  // Any command with cs_n high collapses to DESELECT regardless of the other pins.
  function automatic cmd_t decode_cmd(input logic [3:0] raw);
    cmd_t c;
    c = CMD_DESEL;
    if (!raw[3]) begin
      case (raw[2:0])
        3'b000:  c = CMD_LMR;
        3'b001:  c = CMD_REF;
        3'b010:  c = CMD_PRE;
        3'b011:  c = CMD_ACT;
        3'b100:  c = CMD_WRITE;
        3'b101:  c = CMD_READ;
        3'b110:  c = CMD_BST;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/hpdmc_sdrmon_bank.sv
// One SDRAM bank tracker: IDLE/ACTIVE/PRECHARGING state, open row and the
// tRCD/tRP down-counters that gate dependent commands.
module hpdmc_sdrmon_bank
  import hpdmc_sdrmon_pkg::*;
#(
  parameter int ROW_W = 13
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             act_i,
  input  logic             pre_i,
  input  logic             rp_ld_i,
  input  logic [2:0]       tim_rp,
  input  logic [2:0]       tim_rcd,
  input  logic [ROW_W-1:0] row_i,
  output bank_state_t      state_o,
  output logic [ROW_W-1:0] row_o,
  output logic             rcd_zero_o,
  output logic             rp_zero_o
);

  bank_state_t      state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [2:0]       rcd_q, rcd_d;
  logic [2:0]       rp_q, rp_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= BANK_IDLE;
      row_q   <= '0;
      rcd_q   <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      rcd_q   <= rcd_d;
      rp_q    <= rp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rcd_d   = (rcd_q != 3'd0) ? rcd_q - 3'd1 : 3'd0;
    rp_d    = (rp_q  != 3'd0) ? rp_q  - 3'd1 : 3'd0;
    if (act_i) begin
      row_d = row_i;
      rcd_d = tim_rcd;
    end
    if (rp_ld_i) rp_d = tim_rp;
    case (state_q)
      BANK_IDLE:        if (act_i) state_d = BANK_ACTIVE;
      BANK_ACTIVE:      if (pre_i) state_d = BANK_PRECHARGING;
      // Leave PRECHARGING as the counter lands on 0 so ACT is accepted right then.
      BANK_PRECHARGING: if (rp_d == 3'd0) state_d = BANK_IDLE;
      default:          state_d = BANK_IDLE;
    endcase
  end

  assign state_o    = state_q;
  assign row_o      = row_q;
  assign rcd_zero_o = (rcd_q == 3'd0);
  assign rp_zero_o  = (rp_q == 3'd0);

endmodule

// File: rtl/hpdmc_sdrmon.sv
// SDRAM command-bus monitor: checks bank/timing legality, emits read/write
// strobes with the word address. Define HPDMC_SDRMON_REFI_CHECK_EN for the refresh watchdog.
module hpdmc_sdrmon
  import hpdmc_sdrmon_pkg::*;
#(
  parameter int sdram_depth       = 25,
  parameter int sdram_columndepth = 10
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [2:0]             tim_rp,
  input  logic [2:0]             tim_rcd,
  input  logic [3:0]             tim_rfc,
  input  logic [10:0]            tim_refi,
  input  logic                   sdram_cs_n,
  input  logic                   sdram_ras_n,
  input  logic                   sdram_cas_n,
  input  logic                   sdram_we_n,
  input  logic [12:0]            sdram_adr,
  input  logic [1:0]             sdram_ba,
  output logic                   rd_stb,
  output logic                   wr_stb,
  output logic [sdram_depth-2:0] word_adr,
  output logic [3:0]             bank_open,
  input  logic                   err_clr,
  output logic [7:0]             err_flags
);

  localparam int ROW_W = sdram_depth - sdram_columndepth - 2;

  cmd_t                   cmd;
  bank_state_t            st [NUM_BANKS];
  logic [ROW_W-1:0]       row [NUM_BANKS];
  logic [NUM_BANKS-1:0]   rcd_zero, rp_zero, act_v, pre_v, rp_ld_v;
  logic                   rfc_busy, all_ready, refi_err;
  logic [7:0]             new_err;
  logic [7:0]             err_q, err_d;
  logic [3:0]             rfc_q, rfc_d;
  logic                   rd_q, rd_d, wr_q, wr_d;
  logic [sdram_depth-2:0] word_adr_q, word_adr_d;

  assign cmd = decode_cmd({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n});

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    hpdmc_sdrmon_bank #(.ROW_W(ROW_W)) u_bank (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .act_i      (act_v[b]),
      .pre_i      (pre_v[b]),
      .rp_ld_i    (rp_ld_v[b]),
      .tim_rp     (tim_rp),
      .tim_rcd    (tim_rcd),
      .row_i      (sdram_adr[ROW_W-1:0]),
      .state_o    (st[b]),
      .row_o      (row[b]),
      .rcd_zero_o (rcd_zero[b]),
      .rp_zero_o  (rp_zero[b])
    );
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_q      <= '0;
      rfc_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      word_adr_q <= '0;
    end else begin
      err_q      <= err_d;
      rfc_q      <= rfc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      word_adr_q <= word_adr_d;
    end
  end

  always_comb begin
    bank_open = '0;
    all_ready = 1'b1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_open[b] = (st[b] == BANK_ACTIVE);
      // A bank only counts as quiescent once its tRP has fully elapsed.
      if (st[b] != BANK_IDLE || !rp_zero[b]) all_ready = 1'b0;
    end
  end

  always_comb begin
    new_err    = '0;
    act_v      = '0;
    pre_v      = '0;
    rp_ld_v    = '0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    word_adr_d = word_adr_q;
    rfc_busy   = (rfc_q != 4'd0);
    rfc_d      = rfc_busy ? rfc_q - 4'd1 : 4'd0;
    if (rfc_busy && cmd != CMD_NOP && cmd != CMD_DESEL) new_err[ERR_RFC] = 1'b1;
    case (cmd)
      CMD_ACT: begin
        if (st[sdram_ba] != BANK_IDLE || !rp_zero[sdram_ba]) new_err[ERR_ACT] = 1'b1;
        else if (!rfc_busy) act_v[sdram_ba] = 1'b1;
      end
      CMD_READ, CMD_WRITE: begin
        new_err[ERR_RW_STATE] = (st[sdram_ba] != BANK_ACTIVE);
        new_err[ERR_RCD]      = !rcd_zero[sdram_ba];
        new_err[ERR_AUTOPRE]  = sdram_adr[10];
        if (new_err == 8'd0) begin
          rd_d       = (cmd == CMD_READ);
          wr_d       = (cmd == CMD_WRITE);
          word_adr_d = {row[sdram_ba], sdram_ba, sdram_adr[sdram_columndepth-1:1]};
        end
      end
      CMD_PRE: begin
        if (!rfc_busy) begin
          if (sdram_adr[10]) begin
            pre_v   = '1;
            rp_ld_v = '1;
          end else begin
            pre_v[sdram_ba]   = 1'b1;
            rp_ld_v[sdram_ba] = (st[sdram_ba] != BANK_IDLE);
          end
        end
      end
      CMD_REF: begin
        new_err[ERR_REF] = !all_ready;
        rfc_d            = tim_rfc;
      end
      CMD_LMR: new_err[ERR_LMR] = !all_ready;
      default: ;
    endcase
    new_err[ERR_REFI] = refi_err;
    err_d = (err_clr ? 8'd0 : err_q) | new_err;
  end

`ifdef HPDMC_SDRMON_REFI_CHECK_EN
  logic [10:0] refi_q, refi_d;
  logic [4:0]  grace_q, grace_d;
  logic        armed_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      refi_q  <= '0;
      grace_q <= '0;
      armed_q <= 1'b0;
    end else begin
      refi_q  <= refi_d;
      grace_q <= grace_d;
      armed_q <= 1'b1;
    end
  end

  // First cycle out of reset loads tREFI, as does every REF.
  always_comb begin
    refi_d  = (refi_q != 11'd0) ? refi_q - 11'd1 : 11'd0;
    grace_d = grace_q;
    if (!armed_q || cmd == CMD_REF) begin
      refi_d  = tim_refi;
      grace_d = '0;
    end else if (refi_q == 11'd0 && grace_q != 5'h1f) begin
      grace_d = grace_q + 5'd1;
    end
    refi_err = armed_q && (refi_q == 11'd0) && (grace_q >= ({1'b0, tim_rfc} + 5'd4));
  end
`else
  logic unused_refi;
  assign unused_refi = ^tim_refi;
  assign refi_err    = 1'b0;
`endif

  assign rd_stb    = rd_q;
  assign wr_stb    = wr_q;
  assign word_adr  = word_adr_q;
  assign err_flags = err_q;

endmodule

// File: tb/tb_hpdmc_sdrmon.sv
// Directed bench for hpdmc_sdrmon: legal/illegal command sequences with
// hand-computed strobes, word addresses and error flags.
module tb_hpdmc_sdrmon;

  localparam logic [3:0] C_NOP   = 4'b0111;
  localparam logic [3:0] C_ACT   = 4'b0011;
  localparam logic [3:0] C_READ  = 4'b0101;
  localparam logic [3:0] C_WRITE = 4'b0100;
  localparam logic [3:0] C_PRE   = 4'b0010;
  localparam logic [3:0] C_REF   = 4'b0001;
  localparam logic [3:0] C_LMR   = 4'b0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [2:0]  tim_rp, tim_rcd;
  logic [3:0]  tim_rfc;
  logic [10:0] tim_refi;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [12:0] sdram_adr;
  logic [1:0]  sdram_ba;
  logic        rd_stb, wr_stb;
  logic [23:0] word_adr;
  logic [3:0]  bank_open;
  logic        err_clr;
  logic [7:0]  err_flags;

  int n_chk = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  hpdmc_sdrmon dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .tim_rp      (tim_rp),
    .tim_rcd     (tim_rcd),
    .tim_rfc     (tim_rfc),
    .tim_refi    (tim_refi),
    .sdram_cs_n  (sdram_cs_n),
    .sdram_ras_n (sdram_ras_n),
    .sdram_cas_n (sdram_cas_n),
    .sdram_we_n  (sdram_we_n),
    .sdram_adr   (sdram_adr),
    .sdram_ba    (sdram_ba),
    .rd_stb      (rd_stb),
    .wr_stb      (wr_stb),
    .word_adr    (word_adr),
    .bank_open   (bank_open),
    .err_clr     (err_clr),
    .err_flags   (err_flags)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one command for one rising edge, then return 1 time unit after it.
  task automatic do_cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] adr,
                        input logic clr);
    @(negedge sys_clk);
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
    sdram_ba  = ba;
    sdram_adr = adr;
    err_clr   = clr;
    @(posedge sys_clk);
    #1;
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = C_NOP;
    err_clr = 1'b0;
  endtask

  task automatic nops(input int n, input logic clr_last);
    for (int i = 0; i < n; i++) do_cmd(C_NOP, 2'd0, 13'd0, clr_last && (i == n - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst_n = 1'b0;
    tim_rp = 3'd2; tim_rcd = 3'd2; tim_rfc = 4'd6; tim_refi = 11'd2047;
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = C_NOP;
    sdram_adr = '0; sdram_ba = '0; err_clr = 1'b0;
    #12;
    chk("rst_bank_open", 32'(bank_open), 32'h0);
    chk("rst_err", 32'(err_flags), 32'h0);
    chk("rst_rd", 32'(rd_stb), 32'h0);
    chk("rst_wr", 32'(wr_stb), 32'h0);
    chk("rst_word_adr", 32'(word_adr), 32'h0);
    @(negedge sys_clk); sys_rst_n = 1'b1;

    // Legal ACT / tRCD wait / READ
    do_cmd(C_ACT, 2'd1, 13'h123, 1'b0);
    nops(2, 1'b0);
    do_cmd(C_READ, 2'd1, 13'h040, 1'b0);
    chk("rd_stb", 32'(rd_stb), 32'h1);
    chk("rd_no_wr", 32'(wr_stb), 32'h0);
    chk("rd_word_adr", 32'(word_adr), 32'({13'h123, 2'b01, 9'h020}));
    chk("rd_err", 32'(err_flags), 32'h0);
    chk("rd_bank_open", 32'(bank_open), 32'h2);
    nops(1, 1'b0);
    chk("rd_stb_pulse", 32'(rd_stb), 32'h0);

    // WRITE too early after ACT, then legal WRITE
    do_cmd(C_ACT, 2'd0, 13'h0AB, 1'b0);
    do_cmd(C_WRITE, 2'd0, 13'h3FE, 1'b0);
    chk("early_wr_err", 32'(err_flags), 32'h04);
    chk("early_wr_stb", 32'(wr_stb), 32'h0);
    nops(1, 1'b1);
    chk("clr1", 32'(err_flags), 32'h0);
    do_cmd(C_WRITE, 2'd0, 13'h3FE, 1'b0);
    chk("wr_stb", 32'(wr_stb), 32'h1);
    chk("wr_word_adr", 32'(word_adr), 32'({13'h0AB, 2'b00, 9'h1FF}));
    chk("wr_err", 32'(err_flags), 32'h0);

    // READ to an idle bank, auto-precharge, simultaneous flags, clear priority
    do_cmd(C_READ, 2'd2, 13'h040, 1'b0);
    chk("idle_rd_err", 32'(err_flags), 32'h02);
    chk("idle_rd_stb", 32'(rd_stb), 32'h0);
    nops(1, 1'b1);
    chk("clr2", 32'(err_flags), 32'h0);
    do_cmd(C_READ, 2'd1, 13'h440, 1'b0);
    chk("autopre_err", 32'(err_flags), 32'h40);
    chk("autopre_stb", 32'(rd_stb), 32'h0);
    nops(1, 1'b1);
    do_cmd(C_READ, 2'd2, 13'h440, 1'b0);
    chk("multi_err", 32'(err_flags), 32'h42);
    do_cmd(C_READ, 2'd2, 13'h040, 1'b1);
    chk("clr_vs_new", 32'(err_flags), 32'h02);
    nops(1, 1'b1);

    // PRE-all, REF too soon, then correct spacing and ACT inside tRFC
    do_cmd(C_PRE, 2'd0, 13'h400, 1'b0);
    chk("preall_open", 32'(bank_open), 32'h0);
    nops(1, 1'b0);
    do_cmd(C_REF, 2'd0, 13'h0, 1'b0);
    chk("ref_early_err", 32'(err_flags), 32'h08);
    nops(8, 1'b1);
    chk("clr3", 32'(err_flags), 32'h0);
    do_cmd(C_PRE, 2'd0, 13'h400, 1'b0);
    nops(3, 1'b0);
    do_cmd(C_REF, 2'd0, 13'h0, 1'b0);
    chk("ref_ok_err", 32'(err_flags), 32'h0);
    nops(2, 1'b0);
    do_cmd(C_ACT, 2'd0, 13'h001, 1'b0);
    chk("act_in_rfc_err", 32'(err_flags), 32'h10);
    chk("act_in_rfc_open", 32'(bank_open), 32'h0);
    nops(8, 1'b1);

    // PRE to idle bank is a no-op; LMR legality
    do_cmd(C_PRE, 2'd2, 13'h0, 1'b0);
    chk("pre_idle_err", 32'(err_flags), 32'h0);
    do_cmd(C_LMR, 2'd0, 13'h0, 1'b0);
    chk("lmr_ok_err", 32'(err_flags), 32'h0);
    do_cmd(C_ACT, 2'd2, 13'h055, 1'b0);
    do_cmd(C_LMR, 2'd0, 13'h0, 1'b0);
    chk("lmr_open_err", 32'(err_flags), 32'h20);
    nops(1, 1'b1);

    // Asynchronous reset with bank3 mid-tRCD
    do_cmd(C_ACT, 2'd3, 13'h077, 1'b0);
    chk("pre_rst_open", 32'(bank_open), 32'hC);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_open", 32'(bank_open), 32'h0);
    chk("async_rst_err", 32'(err_flags), 32'h0);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    do_cmd(C_ACT, 2'd3, 13'h077, 1'b0);
    chk("post_rst_open", 32'(bank_open), 32'h8);
    chk("post_rst_err", 32'(err_flags), 32'h0);

    // Refresh watchdog
    @(negedge sys_clk);
    sys_rst_n = 1'b0; tim_refi = 11'd20; tim_rfc = 4'd6;
    @(negedge sys_clk); sys_rst_n = 1'b1;
    nops(45, 1'b0);
`ifdef HPDMC_SDRMON_REFI_CHECK_EN
    chk("refi_err", 32'(err_flags), 32'h80);
`else
    chk("refi_err", 32'(err_flags), 32'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
